// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Provides the common IDLE/SHIFT/DONE state encoding.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
// master: requester (start, a, b); slave: subtractor (busy, done, diff, bout).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives.
// Ports: a, b, bin in; d (a-b-bin bit), bout (borrow out) out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic ab_x;
  logic a_n;
  logic ab_xn;
  logic t0;
  logic t1;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (d, ab_x, bin);
  not g_n0 (a_n, a);
  not g_n1 (ab_xn, ab_x);
  and g_a0 (t0, a_n, b);
  and g_a1 (t1, ab_xn, bin);
  or  g_o0 (bout, t0, t1);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports: clk, rst_n (async low), bus (slave: start,a,b -> busy,done,diff,bout).
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bout_q;
  logic             d_bit;
  logic             br_nxt;
  logic             last;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_nxt)
  );

  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_n = ST_SHIFT;
      ST_SHIFT: if (last) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            diff_q <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_nxt;
          if (last) begin
            bout_q <= br_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == ST_SHIFT) || (state == ST_DONE);
  assign bus.done = (state == ST_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Directed cases plus random operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return W'(r);
  endfunction

  function automatic logic m_bout(input logic [W-1:0] x,
                                  input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, W);
  endtask

  task automatic op(input string tag, input logic [W-1:0] x,
                    input logic [W-1:0] y);
    int lat;
    accept(x, y);
    wait_done(tag, lat);
    chk({tag, "_diff"}, bus.diff, m_diff(x, y));
    chk({tag, "_bout"}, bus.bout, m_bout(x, y));
  endtask

  initial begin
    int lat;
    int seen;
    int cyc;
    int t[$];
    logic [W-1:0] x;
    logic [W-1:0] y;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    rst_n = 1'b1;

    // Latency and busy span on the first directed case
    accept(8'h05, 8'h03);
    seen = 0;
    lat = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.busy) seen++;
      if (bus.done && lat == 0) lat = i + 2;
    end
    chk("t1_busy_cycles", seen, W + 1);
    chk("t1_done_cycle", lat, W + 2);
    chk("t1_diff", bus.diff, 8'h02);
    chk("t1_bout", bus.bout, 0);

    op("t2", 8'h03, 8'h05);
    repeat (4) @(negedge clk);
    chk("t2_hold_diff", bus.diff, 8'hFE);
    chk("t2_hold_bout", bus.bout, 1);
    chk("t2_idle_busy", bus.busy, 0);
    chk("t2_idle_done", bus.done, 0);

    op("t3", 8'h00, 8'h00);
    op("t4", 8'hFF, 8'h01);
    op("t5", 8'h00, 8'h01);
    op("t6", 8'h80, 8'h7F);

    // Start while busy is ignored
    accept(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_to", lat < 40, 1);
    chk("ign_diff", bus.diff, 8'h0F);
    chk("ign_bout", bus.bout, 0);
    @(negedge clk);
    chk("ign_no_restart", bus.busy, 0);

    // Reset mid-operation
    accept(8'h33, 8'h11);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_diff", bus.diff, 0);
    chk("arst_bout", bus.bout, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("arst_no_done", seen, 0);
    op("t8", 8'h09, 8'h04);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h20;
    bus.b = 8'h10;
    cyc = 0;
    while (t.size() < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        t.push_back(cyc);
        chk("b2b_diff", bus.diff, 8'h10);
        chk("b2b_bout", bus.bout, 0);
      end
    end
    bus.start = 1'b0;
    chk("b2b_pulses", t.size(), 3);
    if (t.size() == 3) begin
      chk("b2b_per0", t[1] - t[0], W + 2);
      chk("b2b_per1", t[2] - t[1], W + 2);
    end
    repeat (3) @(negedge clk);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if (i == 0) y = x;
      op("rnd", x, y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
